// File: rtl/franco_xor_top.sv
// franco_xor_top
// Serial XOR cipher. A WIDTH-bit key and a WIDTH-bit message are shifted in
// MSB first from one data pin. Their XOR is then shifted out MSB first, one
// bit per slow period, and a done flag is raised. All sequencing advances on
// "ticks", which are the iClk edges where the internally divided clock
// oClk_slow rises.
//
// Ports:
//   iClk       system clock (all flops on rising edge)
//   iRst       asynchronous active-high reset
//   iEn        global enable; 0 freezes every register, divider included
//   iData_in   serial input bit for key/message loading
//   iLoad_key  shift iData_in into the key on each tick (has priority)
//   iLoad_msg  shift iData_in into the message on each tick
//   oClk_slow  divided clock, period 2*DIV iClk cycles, 50% duty
//   oData_out  serial result bit (0 outside the output phase)
//   oDone_flag high once the whole result has been shifted out
module franco_xor_top #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iEn,
    input  logic iData_in,
    input  logic iLoad_key,
    input  logic iLoad_msg,
    output logic oClk_slow,
    output logic oData_out,
    output logic oDone_flag
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        OUT  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [DW-1:0]    divCnt_r;
    logic             clkSlow_r;
    logic             tick_s;

    state_t           state_r,   state_s;
    logic [WIDTH-1:0] key_r,     key_s;
    logic [WIDTH-1:0] msg_r,     msg_s;
    logic [CW-1:0]    keyCnt_r,  keyCnt_s;
    logic [CW-1:0]    msgCnt_r,  msgCnt_s;
    logic [WIDTH-1:0] outSr_r,   outSr_s;
    logic [CW-1:0]    outCnt_r,  outCnt_s;
    logic             dataOut_r, dataOut_s;
    logic             done_r,    done_s;

    // Tick is the enabled edge on which the slow clock goes from 0 to 1.
    assign tick_s = iEn && (divCnt_r == DIV_LAST) && !clkSlow_r;

    // Clock divider: count 0..DIV-1 and toggle the slow clock on wrap.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            divCnt_r  <= {DW{1'b0}};
            clkSlow_r <= 1'b0;
        end else if (iEn) begin
            if (divCnt_r == DIV_LAST) begin
                divCnt_r  <= {DW{1'b0}};
                clkSlow_r <= ~clkSlow_r;
            end else begin
                divCnt_r  <= divCnt_r + DW'(1);
            end
        end
    end

    // Next-state and datapath decode, evaluated for the coming tick.
    always_comb begin
        state_s   = state_r;
        key_s     = key_r;
        msg_s     = msg_r;
        keyCnt_s  = keyCnt_r;
        msgCnt_s  = msgCnt_r;
        outSr_s   = outSr_r;
        outCnt_s  = outCnt_r;
        dataOut_s = dataOut_r;
        done_s    = done_r;
        case (state_r)
            LOAD: begin
                // Both registers full: start output; loads ignored this tick.
                if ((keyCnt_r == CNT_FULL) && (msgCnt_r == CNT_FULL)) begin
                    outSr_s   = key_r ^ msg_r;
                    dataOut_s = key_r[WIDTH-1] ^ msg_r[WIDTH-1];
                    outCnt_s  = {CW{1'b0}};
                    state_s   = OUT;
                end else if (iLoad_key && (keyCnt_r < CNT_FULL)) begin
                    key_s    = {key_r[WIDTH-2:0], iData_in};
                    keyCnt_s = keyCnt_r + CW'(1);
                end else if (iLoad_msg && (msgCnt_r < CNT_FULL)) begin
                    msg_s    = {msg_r[WIDTH-2:0], iData_in};
                    msgCnt_s = msgCnt_r + CW'(1);
                end else begin
                    state_s = LOAD;
                end
            end
            OUT: begin
                if (outCnt_r < CNT_LAST) begin
                    outSr_s   = {outSr_r[WIDTH-2:0], 1'b0};
                    dataOut_s = outSr_r[WIDTH-2];
                    outCnt_s  = outCnt_r + CW'(1);
                end else begin
                    dataOut_s = 1'b0;
                    done_s    = 1'b1;
                    state_s   = DONE;
                end
            end
            DONE: begin
                // A load request restarts; its bit is the first loaded bit,
                // counted from freshly cleared counters.
                if (iLoad_key) begin
                    key_s    = {key_r[WIDTH-2:0], iData_in};
                    keyCnt_s = CW'(1);
                    msgCnt_s = {CW{1'b0}};
                    done_s   = 1'b0;
                    state_s  = LOAD;
                end else if (iLoad_msg) begin
                    msg_s    = {msg_r[WIDTH-2:0], iData_in};
                    msgCnt_s = CW'(1);
                    keyCnt_s = {CW{1'b0}};
                    done_s   = 1'b0;
                    state_s  = LOAD;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s   = LOAD;
                dataOut_s = 1'b0;
                done_s    = 1'b0;
            end
        endcase
    end

    // Sequencer state and datapath registers, updated only on ticks.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_r   <= LOAD;
            key_r     <= {WIDTH{1'b0}};
            msg_r     <= {WIDTH{1'b0}};
            keyCnt_r  <= {CW{1'b0}};
            msgCnt_r  <= {CW{1'b0}};
            outSr_r   <= {WIDTH{1'b0}};
            outCnt_r  <= {CW{1'b0}};
            dataOut_r <= 1'b0;
            done_r    <= 1'b0;
        end else if (tick_s) begin
            state_r   <= state_s;
            key_r     <= key_s;
            msg_r     <= msg_s;
            keyCnt_r  <= keyCnt_s;
            msgCnt_r  <= msgCnt_s;
            outSr_r   <= outSr_s;
            outCnt_r  <= outCnt_s;
            dataOut_r <= dataOut_s;
            done_r    <= done_s;
        end
    end

    assign oClk_slow  = clkSlow_r;
    assign oData_out  = dataOut_r;
    assign oDone_flag = done_r;

endmodule

// File: tb/tb_franco_xor_top.sv
// Self-checking bench for franco_xor_top (WIDTH=8, DIV=4).
// Ticks are counted by the bench itself from iClk edges; after each tick the
// outputs are compared with a queue-based behavioural model of the cipher.
module tb_franco_xor_top;

    localparam int W = 8;
    localparam int D = 4;

    logic iClk = 1'b0;
    logic iRst = 1'b0;
    logic iEn = 1'b1;
    logic iData_in = 1'b0;
    logic iLoad_key = 1'b0;
    logic iLoad_msg = 1'b0;
    logic oClk_slow;
    logic oData_out;
    logic oDone_flag;

    int errors = 0;
    int checks = 0;

    // Model: loaded bits in arrival order, pending output bits (-1 = done).
    int keyQ[$];
    int msgQ[$];
    int outQ[$];
    bit mDone = 1'b0;
    bit expOut = 1'b0;
    bit expDone = 1'b0;

    typedef struct {
        logic [W-1:0] key;
        logic [W-1:0] msg;
        logic [W-1:0] res;
    } vec_t;

    franco_xor_top #(.WIDTH(W), .DIV(D)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iData_in(iData_in),
        .iLoad_key(iLoad_key), .iLoad_msg(iLoad_msg),
        .oClk_slow(oClk_slow), .oData_out(oData_out), .oDone_flag(oDone_flag)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic modelReset();
        keyQ.delete(); msgQ.delete(); outQ.delete();
        mDone = 1'b0; expOut = 1'b0; expDone = 1'b0;
    endtask

    task automatic modelLoad(input bit lk, input bit lm, input bit d);
        if (lk && keyQ.size() < W) keyQ.push_back(int'(d));
        else if (lm && msgQ.size() < W) msgQ.push_back(int'(d));
    endtask

    task automatic modelTick(input bit lk, input bit lm, input bit d);
        int v;
        expOut = 1'b0;
        if (outQ.size() > 0) begin
            v = outQ.pop_front();
            if (v < 0) begin
                mDone = 1'b1; expDone = 1'b1;
            end else begin
                expOut = v[0];
            end
        end else if (mDone) begin
            if (lk || lm) begin
                keyQ.delete(); msgQ.delete();
                mDone = 1'b0; expDone = 1'b0;
                modelLoad(lk, lm, d);
            end
        end else if (keyQ.size() == W && msgQ.size() == W) begin
            for (int i = 0; i < W; i++) outQ.push_back(keyQ[i] ^ msgQ[i]);
            outQ.push_back(-1);
            v = outQ.pop_front();
            expOut = v[0];
        end else begin
            modelLoad(lk, lm, d);
        end
    endtask

    // One slow period; optional iEn freeze of 20 iClk cycles at offset freezeAt.
    task automatic doTick(input bit lk, input bit lm, input bit d, input int freezeAt, input string tag);
        bit prevOut;
        prevOut = expOut;
        iLoad_key = lk; iLoad_msg = lm; iData_in = d;
        if (freezeAt > 0) begin
            repeat (freezeAt) cyc();
            iEn = 1'b0;
            repeat (20) cyc();
            check({tag, ".frzclk"}, oClk_slow, 1'b1);
            check({tag, ".frzout"}, oData_out, prevOut);
            iEn = 1'b1;
            repeat (2 * D - freezeAt) cyc();
        end else begin
            repeat (2 * D) cyc();
        end
        modelTick(lk, lm, d);
        check({tag, ".clk"}, oClk_slow, 1'b1);
        check({tag, ".out"}, oData_out, expOut);
        check({tag, ".done"}, oDone_flag, expDone);
    endtask

    // Asynchronous reset mid-cycle, then align to a tick checking the divider.
    task automatic resetDut(input string tag);
        @(posedge iClk);
        #3 iRst = 1'b1;
        #1;
        check({tag, ".rstclk"}, oClk_slow, 1'b0);
        check({tag, ".rstout"}, oData_out, 1'b0);
        check({tag, ".rstdone"}, oDone_flag, 1'b0);
        modelReset();
        iLoad_key = 1'b0; iLoad_msg = 1'b0; iData_in = 1'b0;
        repeat (2) @(posedge iClk);
        @(negedge iClk) iRst = 1'b0;
        for (int n = 1; n <= 5 * D; n++) begin
            cyc();
            check({tag, ".divclk"}, oClk_slow, ((n / D) % 2) != 0);
            if (n % (2 * D) == D) modelTick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic runCipher(input logic [W-1:0] k, input logic [W-1:0] m, input logic [W-1:0] expRes,
                             input bit noise, input int freezeBit, input string tag);
        logic [W-1:0] res;
        for (int i = W - 1; i >= 0; i--) doTick(1'b1, 1'b0, k[i], 0, {tag, ".key"});
        for (int i = W - 1; i >= 0; i--) doTick(1'b0, 1'b1, m[i], 0, {tag, ".msg"});
        res = '0;
        for (int b = 0; b < W; b++) begin
            doTick(noise ? 1'($urandom_range(0, 1)) : 1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b0,
                   1'($urandom_range(0, 1)), (b == freezeBit) ? 3 : 0, {tag, ".bit"});
            res = {res[W-2:0], oData_out};
        end
        check({tag, ".result"}, res, expRes);
        doTick(1'b0, 1'b0, 1'b0, 0, {tag, ".end"});
        check({tag, ".flag"}, oDone_flag, 1'b1);
    endtask

    initial begin
        vec_t tbl[5];
        logic [W-1:0] res;
        tbl[0] = '{key: 8'hA5, msg: 8'h3C, res: 8'h99};
        tbl[1] = '{key: 8'h0F, msg: 8'hF0, res: 8'hFF};
        tbl[2] = '{key: 8'h00, msg: 8'h00, res: 8'h00};
        tbl[3] = '{key: 8'h81, msg: 8'h7E, res: 8'hFF};
        tbl[4] = '{key: 8'hC3, msg: 8'hC3, res: 8'h00};

        resetDut("reset");

        // Basic cipher vectors; from the second one on each starts from DONE.
        for (int i = 0; i < 5; i++) begin
            runCipher(tbl[i].key, tbl[i].msg, tbl[i].res, 1'b0, -1, $sformatf("vec%0d", i));
        end

        // Restart from DONE: first load tick must clear the flag.
        doTick(1'b1, 1'b0, 1'b0, 0, "restart");
        check("restart.cleared", oDone_flag, 1'b0);
        for (int i = W - 2; i >= 0; i--) doTick(1'b1, 1'b0, (8'h0F >> i) & 8'h01, 0, "restart.key");
        for (int i = W - 1; i >= 0; i--) doTick(1'b0, 1'b1, (8'hF0 >> i) & 8'h01, 0, "restart.msg");
        res = '0;
        for (int b = 0; b < W; b++) begin
            doTick(1'b0, 1'b0, 1'b0, 0, "restart.bit");
            res = {res[W-2:0], oData_out};
        end
        check("restart.result", res, 8'hFF);
        doTick(1'b0, 1'b0, 1'b0, 0, "restart.end");
        check("restart.flag", oDone_flag, 1'b1);

        // Loads toggled during output must not disturb the stream.
        runCipher(8'h6B, 8'h2D, 8'h46, 1'b1, -1, "noise");

        // Enable freeze in the middle of the output phase.
        runCipher(8'hA5, 8'h3C, 8'h99, 1'b0, 3, "freeze");

        // Priority and saturation: both loads high, then a 9th key bit.
        for (int i = 0; i < W; i++) doTick(1'b1, 1'b1, 1'b1, 0, "prio.both");
        doTick(1'b1, 1'b0, 1'b0, 0, "prio.extra");
        for (int i = 0; i < W; i++) doTick(1'b0, 1'b1, 1'b0, 0, "prio.msg");
        res = '0;
        for (int b = 0; b < W; b++) begin
            doTick(1'b0, 1'b0, 1'b0, 0, "prio.bit");
            res = {res[W-2:0], oData_out};
        end
        check("prio.result", res, 8'hFF);
        doTick(1'b0, 1'b0, 1'b0, 0, "prio.end");

        // Reset in the middle of output (0x55^0x0F=0x5A, second bit is 1).
        for (int i = W - 1; i >= 0; i--) doTick(1'b1, 1'b0, (8'h55 >> i) & 8'h01, 0, "abort.key");
        for (int i = W - 1; i >= 0; i--) doTick(1'b0, 1'b1, (8'h0F >> i) & 8'h01, 0, "abort.msg");
        doTick(1'b0, 1'b0, 1'b0, 0, "abort.bit");
        doTick(1'b0, 1'b0, 1'b0, 0, "abort.bit");
        check("abort.high", oData_out, 1'b1);
        resetDut("abort");
        runCipher(8'h12, 8'h34, 8'h26, 1'b0, -1, "postrst");

        // Random load traffic against the model.
        for (int t = 0; t < 400; t++) begin
            doTick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/franco_xor_top.md
# franco_xor_top

Serial XOR cipher block for a TinyTapeout tile.
- Loads a WIDTH-bit key and a WIDTH-bit message one bit at a time from a single data pin.
- XORs them and shifts the result out serially, then raises a done flag.
- All sequencing is paced by an internally divided slow clock, which is also exported on oClk_slow so an external driver or monitor can sample in step with it.

## Interface
Parameters:
- WIDTH, 8: key, message and result length in bits (≥2).
- DIV, 4: half-period of oClk_slow in iClk cycles (≥1); slow period = 2·DIV iClk cycles.

Ports:
- iClk  in  1  system clock; the only clock, all flops on its rising edge.
- iRst  in  1  reset, asynchronous, active-high.
- iEn  in  1  global enable; when 0, all registers (divider included) hold their values.
- iData_in  in  1  serial input bit for key or message loading.
- iLoad_key  in  1  while 1, each tick shifts iData_in into the key register.
- iLoad_msg  in  1  while 1 (and iLoad_key=0), each tick shifts iData_in into the message register.
- oClk_slow  out  1  divided clock, registered, 50% duty.
- oData_out  out  1  serial result bit, registered.
- oDone_flag  out  1  high after the full result has been shifted out.

## Operation
- Divider:
  - div_cnt runs 0..DIV-1, incrementing each enabled iClk.
  - At DIV-1 it wraps to 0 and oClk_slow toggles.
  - tick = enabled cycle with div_cnt==DIV-1 and oClk_slow==0, i.e. the iClk edge on which oClk_slow rises.
  - All state below changes only on tick edges.
- Registers:
  - key[WIDTH-1:0], msg[WIDTH-1:0] with counters key_cnt, msg_cnt (0..WIDTH).
  - out_sr[WIDTH-1:0] with counter out_cnt.
- States: LOAD, OUT, DONE. Reset state is LOAD.
- LOAD, on each tick:
  - iLoad_key=1 and key_cnt<WIDTH: key <= {key[WIDTH-2:0], iData_in}; key_cnt++. Bits arrive MSB first.
  - Else iLoad_msg=1 and msg_cnt<WIDTH: the same shift into msg; msg_cnt++.
  - iLoad_key has priority when both loads are high. Load requests against a full register are ignored.
  - If key_cnt==WIDTH and msg_cnt==WIDTH at the tick (counts before this tick's update): out_sr <= key^msg, oData_out <= (key^msg)[WIDTH-1], out_cnt <= 0, go to OUT. No load occurs on that tick.
- OUT, on each tick:
  - out_cnt<WIDTH-1: out_sr shifts left, oData_out <= next bit, out_cnt++.
  - out_cnt==WIDTH-1: oData_out <= 0, oDone_flag <= 1, go to DONE.
  - iLoad_key/iLoad_msg are ignored in OUT.
- DONE:
  - oDone_flag stays 1 and oData_out stays 0.
  - On a tick with iLoad_key or iLoad_msg high: clear key_cnt and msg_cnt, oDone_flag <= 0, go to LOAD.
  - That same tick's bit is consumed as the first bit, using the LOAD priority rule.
- oData_out is 0 in LOAD and DONE.

## Timing
- Reset values: oClk_slow=0, oData_out=0, oDone_flag=0, div_cnt=0, all registers and counters 0, state LOAD.
- Reset is asynchronous and takes effect mid-operation; it discards partial loads and aborts output.
- First tick after reset is at the DIV-th enabled iClk edge. Subsequent ticks come every 2·DIV enabled iClk cycles.
- Drive inputs stable around the oClk_slow rising edge; changing them on the falling edge is the intended usage.
- Latency:
  - Last load bit sampled at tick L.
  - Result MSB appears at tick L+1.
  - Each result bit is held for exactly one slow period.
  - Bit 0 appears at tick L+WIDTH.
  - oDone_flag rises at tick L+WIDTH+1.
- iEn=0 freezes everything, including oClk_slow. Ticks resume seamlessly when iEn returns to 1.

## Test plan
- Reset: assert iRst mid-count -> all outputs 0 immediately; with iEn=1, oClk_slow first rises after 4 iClk cycles, then toggles every 4 cycles (period 8).
- Basic cipher (WIDTH=8, DIV=4):
  - Stimulus: load key 0xA5, then msg 0x3C, MSB first, one bit per tick.
  - Required response: oData_out over 8 consecutive slow periods = 1,0,0,1,1,0,0,1 (0x99); oDone_flag=1 one tick after the last bit.
- Priority and saturation: iLoad_key and iLoad_msg both high for 8 ticks with data 0xFF -> only key fills. A 9th key bit is ignored. Then msg 0x00 loads -> output 0xFF.
- Enable freeze: drop iEn for 20 iClk cycles during OUT -> oClk_slow, oData_out and the bit position hold; the sequence completes correctly after iEn returns.
- Restart from DONE: after done, load key 0x0F and msg 0xF0 -> oDone_flag clears on the first load tick; output is 0xFF, then done again.
- Loads during OUT are ignored: toggle iLoad_key with data during output -> the result stream is unchanged.
